// File: rtl/i2c_slave_regfile.sv
// I2C responder emulating a decoder register file.
// Sub-address/data writes, auto-increment reads, bench peek port.
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h5C,
  parameter int         DEPTH    = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] peek_addr,
  output logic [7:0] peek_data
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_SUB,
    S_SUB_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  logic          r_scl_s1, r_scl_s2, r_scl_d;
  logic          r_sda_s1, r_sda_s2, r_sda_d;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bitcnt, w_bitcnt_nxt;
  logic [6:0]    r_shift, w_shift_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic          r_rw, w_rw_nxt;
  logic          r_mack, w_mack_nxt;
  logic          r_ninth, w_ninth_nxt;
  logic          r_oe, w_oe_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_wr_en, w_wr_en;
  logic [7:0]    r_wr_addr, w_wr_addr_nxt;
  logic [7:0]    r_wr_data, w_wr_data_nxt;
  logic [7:0]    r_mem [DEPTH];

  logic          w_scl_hi, w_scl_rise, w_scl_fall;
  logic          w_start, w_stop, w_last;
  logic [7:0]    w_byte, w_rd_byte;

  assign w_scl_hi   = r_scl_s2 & r_scl_d;
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = w_scl_hi & r_sda_d & ~r_sda_s2;
  assign w_stop     = w_scl_hi & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift, r_sda_s2};
  assign w_last     = (r_bitcnt == 3'd7);
  assign w_rd_byte  = r_mem[r_ptr];

  assign sda_oe    = r_oe;
  assign busy      = r_busy;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign peek_data = r_mem[AW'(peek_addr)];

  // Synchronize the bus lines; idle bus level is high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  // State and protocol registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_mack    <= 1'b0;
      r_ninth   <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ptr     <= w_ptr_nxt;
      r_rw      <= w_rw_nxt;
      r_mack    <= w_mack_nxt;
      r_ninth   <= w_ninth_nxt;
      r_oe      <= w_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  // Register array: cleared on reset, written on byte commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

  // Next-state and datapath decode; START/STOP override all states.
  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_rw_nxt      = r_rw;
    w_mack_nxt    = r_mack;
    w_ninth_nxt   = r_ninth;
    w_oe_nxt      = r_oe;
    w_busy_nxt    = r_busy;
    w_wr_en       = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    unique case (1'b1)
      w_stop: begin
        w_state_nxt  = S_IDLE;
        w_oe_nxt     = 1'b0;
        w_busy_nxt   = 1'b0;
        w_bitcnt_nxt = '0;
        w_ninth_nxt  = 1'b0;
      end
      w_start: begin
        w_state_nxt  = S_ADDR;
        w_oe_nxt     = 1'b0;
        w_busy_nxt   = 1'b1;
        w_bitcnt_nxt = '0;
        w_ninth_nxt  = 1'b0;
      end
      default: begin
        case (r_state)
          S_ADDR, S_SUB, S_WDATA: begin
            if (w_scl_rise) begin
              w_shift_nxt  = w_byte[6:0];
              w_bitcnt_nxt = r_bitcnt + 3'd1;
              w_ninth_nxt  = 1'b0;
              if (w_last) begin
                if (r_state == S_ADDR) begin
                  w_rw_nxt    = w_byte[0];
                  w_state_nxt = (w_byte[7:1] == DEV_ADDR) ?
                                S_ADDR_ACK : S_IGNORE;
                end else if (r_state == S_SUB) begin
                  w_ptr_nxt   = AW'(w_byte);
                  w_state_nxt = S_SUB_ACK;
                end else begin
                  w_wr_en       = 1'b1;
                  w_wr_addr_nxt = 8'(r_ptr);
                  w_wr_data_nxt = w_byte;
                  w_ptr_nxt     = r_ptr + AW'(1);
                  w_state_nxt   = S_WDATA_ACK;
                end
              end
            end
          end
          S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
            if (w_scl_rise) begin
              w_ninth_nxt = 1'b1;
            end else if (w_scl_fall) begin
              if (!r_ninth) begin
                w_oe_nxt = 1'b1;
              end else begin
                w_oe_nxt     = 1'b0;
                w_ninth_nxt  = 1'b0;
                w_bitcnt_nxt = '0;
                if (r_state != S_ADDR_ACK) begin
                  w_state_nxt = S_WDATA;
                end else if (r_rw) begin
                  w_state_nxt = S_RDATA;
                  w_oe_nxt    = ~w_rd_byte[7];
                end else begin
                  w_state_nxt = S_SUB;
                end
              end
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              w_bitcnt_nxt = r_bitcnt + 3'd1;
              if (w_last) begin
                w_state_nxt = S_RDATA_ACK;
                w_ninth_nxt = 1'b0;
              end
            end else if (w_scl_fall) begin
              w_oe_nxt = ~w_rd_byte[3'd7 - r_bitcnt];
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              w_ninth_nxt = 1'b1;
              w_mack_nxt  = ~r_sda_s2;
              if (!r_sda_s2) w_ptr_nxt = r_ptr + AW'(1);
            end else if (w_scl_fall) begin
              if (!r_ninth) begin
                w_oe_nxt = 1'b0;
              end else if (r_mack) begin
                w_state_nxt  = S_RDATA;
                w_ninth_nxt  = 1'b0;
                w_bitcnt_nxt = '0;
                w_oe_nxt     = ~w_rd_byte[7];
              end else begin
                w_state_nxt = S_IGNORE;
                w_ninth_nxt = 1'b0;
                w_oe_nxt    = 1'b0;
              end
            end
          end
          S_IGNORE: w_oe_nxt = 1'b0;
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile.
// Bench drives SCL/SDA as an open-drain I2C master.
module tb_i2c_slave_regfile;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_en;
  logic [7:0] wr_addr, wr_data;
  logic [7:0] peek_addr = 8'h00;
  logic [7:0] peek_data;

  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .peek_addr (peek_addr),
    .peek_data (peek_data)
  );

  logic [15:0] cq[$];
  int          oe_cnt = 0;

  // Record every committed byte and every cycle SDA is pulled.
  always @(negedge clk) begin
    if (wr_en === 1'b1) cq.push_back({wr_addr, wr_data});
    if (sda_oe === 1'b1) oe_cnt++;
  end

  int n_chk = 0;
  int n_fail = 0;
  int rd = 0;

  typedef struct {
    logic [7:0] sub;
    logic [7:0] data;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt [5];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(T);
    scl = 1'b1;
    tick(T);
    m_sda = 1'b0;
    tick(T);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(T);
    scl = 1'b1;
    tick(T);
    m_sda = 1'b1;
    tick(T);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i];
      tick(T);
      scl = 1'b1;
      tick(T);
      scl = 1'b0;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda = 1'b1;
    tick(T);
    scl = 1'b1;
    tick(T / 2);
    ack = (sda_line === 1'b0);
    tick(T / 2);
    scl = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic [7:0] v;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1;
      tick(T);
      scl = 1'b1;
      tick(T / 2);
      v[i] = sda_line;
      tick(T / 2);
      scl = 1'b0;
    end
    m_sda = ~ack;
    tick(T);
    scl = 1'b1;
    tick(T);
    scl = 1'b0;
    b = v;
  endtask

  task automatic wr_txn(input logic [7:0] sub, input logic [7:0] d,
                        output int acks);
    logic a;
    acks = 0;
    i2c_start();
    write_byte(8'hB8, a);
    acks += int'(a);
    write_byte(sub, a);
    acks += int'(a);
    write_byte(d, a);
    acks += int'(a);
    i2c_stop();
  endtask

  task automatic expect_commit(input string name, input logic [7:0] a,
                               input logic [7:0] d);
    check({name, "_present"}, 32'(cq.size() > rd), 32'd1);
    if (cq.size() > rd) begin
      check(name, 32'(cq[rd]), {16'h0, a, d});
      rd++;
    end
  endtask

  task automatic peek_chk(input string name, input logic [7:0] a,
                          input logic [7:0] d);
    peek_addr = a;
    #1;
    check(name, 32'(peek_data), 32'(d));
  endtask

  initial begin
    logic       a;
    logic [7:0] v;
    int         o, acks, nz;

    vt[0] = '{8'h00, 8'h02, 8'h00, 8'h02};
    vt[1] = '{8'h03, 8'h0D, 8'h03, 8'h0D};
    vt[2] = '{8'h08, 8'h4C, 8'h08, 8'h4C};
    vt[3] = '{8'h0F, 8'h01, 8'h0F, 8'h01};
    vt[4] = '{8'h1B, 8'h96, 8'h1B, 8'h96};

    tick(4);
    reset_n = 1'b1;
    tick(4);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    peek_chk("rst_peek03", 8'h03, 8'h00);

    // Basic write: sub 0x03, data 0x0A, 0x55.
    i2c_start();
    check("busy_start", 32'(busy), 1);
    write_byte(8'hB8, a);
    check("ack_addr", 32'(a), 1);
    write_byte(8'h03, a);
    check("ack_sub", 32'(a), 1);
    write_byte(8'h0A, a);
    check("ack_d0", 32'(a), 1);
    write_byte(8'h55, a);
    check("ack_d1", 32'(a), 1);
    check("busy_mid", 32'(busy), 1);
    i2c_stop();
    check("busy_stop", 32'(busy), 0);
    expect_commit("wr0", 8'h03, 8'h0A);
    expect_commit("wr1", 8'h04, 8'h55);
    check("wr_count", 32'(cq.size()), 32'(rd));
    peek_chk("peek03", 8'h03, 8'h0A);
    peek_chk("peek04", 8'h04, 8'h55);

    // Read via repeated start, ACK then NACK.
    i2c_start();
    write_byte(8'hB8, a);
    write_byte(8'h03, a);
    i2c_start();
    write_byte(8'hB9, a);
    check("ack_raddr", 32'(a), 1);
    read_byte(v, 1'b1);
    check("rd0", 32'(v), 32'h0A);
    read_byte(v, 1'b0);
    check("rd1", 32'(v), 32'h55);
    tick(T);
    check("nack_release", 32'(sda_oe), 0);
    o = oe_cnt;
    send_bits(8'hFF, 8);
    check("ignore_no_drive", 32'(oe_cnt), 32'(o));
    check("ignore_busy", 32'(busy), 1);
    i2c_stop();
    check("rd_busy_stop", 32'(busy), 0);
    check("rd_no_wr", 32'(cq.size()), 32'(rd));

    // Read without sub-address starts at the kept pointer.
    i2c_start();
    write_byte(8'hB9, a);
    read_byte(v, 1'b0);
    check("rd_curptr", 32'(v), 32'h55);
    i2c_stop();

    // Address mismatch.
    o = oe_cnt;
    i2c_start();
    write_byte(8'hBA, a);
    check("nack_bad_addr", 32'(a), 0);
    write_byte(8'h10, a);
    write_byte(8'hFF, a);
    i2c_stop();
    check("bad_no_drive", 32'(oe_cnt), 32'(o));
    check("bad_no_wr", 32'(cq.size()), 32'(rd));
    peek_chk("bad_peek10", 8'h10, 8'h00);

    // Pointer wrap and aborted third byte.
    i2c_start();
    write_byte(8'hB8, a);
    write_byte(8'hFF, a);
    write_byte(8'h11, a);
    write_byte(8'h22, a);
    send_bits(8'h33, 5);
    i2c_stop();
    expect_commit("wrapFF", 8'hFF, 8'h11);
    expect_commit("wrap00", 8'h00, 8'h22);
    check("abort_count", 32'(cq.size()), 32'(rd));
    peek_chk("peekFF", 8'hFF, 8'h11);
    peek_chk("peek00", 8'h00, 8'h22);
    peek_chk("peek01", 8'h01, 8'h00);

    // Reset while the slave is driving ACK.
    i2c_start();
    send_bits(8'hB8, 8);
    m_sda = 1'b1;
    tick(T);
    @(negedge clk);
    check("ack_driven", 32'(sda_oe), 1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_oe", 32'(sda_oe), 0);
    check("rstmid_busy", 32'(busy), 0);
    tick(3);
    scl = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2 * T);
    check("rstmid_wr_data", 32'(wr_data), 0);
    nz = 0;
    for (int i = 0; i < 256; i++) begin
      peek_addr = 8'(i);
      #1;
      if (peek_data !== 8'h00) nz++;
    end
    check("rstmid_mem_clear", 32'(nz), 0);
    wr_txn(8'h20, 8'h5A, acks);
    check("post_rst_acks", 32'(acks), 3);
    expect_commit("post_rst_wr", 8'h20, 8'h5A);
    peek_chk("post_rst_peek", 8'h20, 8'h5A);

    // Configuration image replay.
    for (int i = 0; i < 5; i++) begin
      wr_txn(vt[i].sub, vt[i].data, acks);
      check($sformatf("cfg%0d_acks", i), 32'(acks), 3);
      expect_commit($sformatf("cfg%0d_wr", i),
                    vt[i].exp_addr, vt[i].exp_data);
    end
    check("cfg_count", 32'(cq.size()), 32'(rd));
    for (int i = 0; i < 5; i++) begin
      peek_chk($sformatf("cfg%0d_peek", i),
               vt[i].exp_addr, vt[i].exp_data);
    end
    peek_chk("cfg_keep20", 8'h20, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
